// File: rtl/mux_scan_ctrl.sv
// Round-robin multiplexed-display scanner with optional post-advance blanking.
// Define MUX_SCAN_BLANK_EN to enable the BLANKING state and the BLANK parameter.
module mux_scan_ctrl #(
  parameter int PRESCALE = 100000,
  parameter int BLANK    = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] ch_en,
  output logic [1:0] S,
  output logic [3:0] AN,
  output logic       tick,
  output logic       blank
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

`ifdef MUX_SCAN_BLANK_EN
  localparam int BLANK_EFF = BLANK;
`else
  // BLANK has no effect without blanking support
  localparam int BLANK_EFF = 0 * BLANK;
`endif

  localparam bit USE_BLANK = (BLANK_EFF > 0);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_EFF);

  typedef enum logic [1:0] {
    IDLE,
    BLANKING,
    SHOW
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic [1:0]    s_adv;
  logic [1:0]    s_wake;
  logic [1:0]    s_nxt;
  logic          active;
  logic          restart;

  // Next enabled channel after cur; holds when no other channel is on.
  function automatic logic [1:0] rr(
    input logic [1:0] cur,
    input logic [3:0] m
  );
    logic [1:0] r;
    r = cur;
    for (int k = 3; k >= 1; k--) begin
      if (m[cur + 2'(k)]) r = cur + 2'(k);
    end
    return r;
  endfunction

  function automatic logic [3:0] strobe(
    input logic [1:0] sel,
    input logic [3:0] m
  );
    return m[sel] ? ~(4'b0001 << sel) : 4'b1111;
  endfunction

  assign active  = en && (ch_en != 4'b0000);
  assign cnt_inc = cnt + CW'(1);
  assign s_adv   = rr(S, ch_en);
  assign s_wake  = ch_en[S] ? S : s_adv;
  assign restart = (state == IDLE) || (cnt == LAST);
  assign s_nxt   = (state == IDLE) ? s_wake : s_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      S     <= 2'b00;
      AN    <= 4'b1111;
      tick  <= 1'b0;
      blank <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (!active) begin
        state <= IDLE;
        cnt   <= '0;
        AN    <= 4'b1111;
        blank <= 1'b1;
      end else if (restart) begin
        // Leaving IDLE or wrapping the prescaler starts a new period
        cnt  <= '0;
        S    <= s_nxt;
        tick <= (state != IDLE) || (s_wake != S);
        if (USE_BLANK) begin
          state <= BLANKING;
          AN    <= 4'b1111;
          blank <= 1'b1;
        end else begin
          state <= SHOW;
          AN    <= strobe(s_nxt, ch_en);
          blank <= 1'b0;
        end
      end else begin
        cnt <= cnt_inc;
        if (state == BLANKING && cnt_inc != BLANK_END) begin
          state <= BLANKING;
          AN    <= 4'b1111;
          blank <= 1'b1;
        end else begin
          state <= SHOW;
          AN    <= strobe(S, ch_en);
          blank <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: vector table, directed corner sequences
// and random stimulus against a period-position reference model.
module tb_mux_scan_ctrl;

  localparam int P = 4;
  localparam int B = 1;
`ifdef MUX_SCAN_BLANK_EN
  localparam int BE = B;
`else
  localparam int BE = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] ch_en = 4'hF;
  logic [1:0] s;
  logic [3:0] an;
  logic       tick;
  logic       blank;
  logic [1:0] s2;
  logic [3:0] an2;
  logic       tick2;
  logic       blank2;

  mux_scan_ctrl #(.PRESCALE(P), .BLANK(B)) dut (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en),
    .S(s), .AN(an), .tick(tick), .blank(blank)
  );

  mux_scan_ctrl #(.PRESCALE(2), .BLANK(0)) dut2 (
    .clk(clk), .rst(rst), .en(en), .ch_en(ch_en),
    .S(s2), .AN(an2), .tick(tick2), .blank(blank2)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
  endtask

  // Reference: is the scan running, where in the period are we, which channel
  bit         m_act = 1'b0;
  bit         m_fresh = 1'b0;
  bit         m_tick = 1'b0;
  int         m_pos = 0;
  logic [1:0] m_s = 2'd0;
  logic [3:0] m_mask = 4'h0;

  function automatic logic [1:0] pick(input logic [1:0] cur,
                                      input logic [3:0] m, input int from);
    for (int k = from; k <= 3; k++) begin
      int c = (int'(cur) + k) % 4;
      if (m[c]) return 2'(c);
    end
    return cur;
  endfunction

  task automatic model_step();
    logic [1:0] ns;
    m_mask  = ch_en;
    m_tick  = 1'b0;
    m_fresh = 1'b0;
    if (rst) begin
      m_act = 1'b0; m_pos = 0; m_s = 2'd0; m_fresh = 1'b1;
    end else if (!en || ch_en == 4'h0) begin
      m_act = 1'b0; m_pos = 0;
    end else if (!m_act) begin
      m_act = 1'b1; m_pos = 0;
      ns = pick(m_s, ch_en, 0);
      m_tick = (ns != m_s);
      m_s = ns;
    end else begin
      m_pos = (m_pos + 1) % P;
      if (m_pos == 0) begin
        m_s = pick(m_s, ch_en, 1);
        m_tick = 1'b1;
      end
    end
  endtask

  task automatic model_check();
    bit hidden;
    logic [3:0] one;
    logic [3:0] exp_an;
    one = 4'b0001;
    hidden = !m_act || (m_pos < BE);
    exp_an = (!hidden && m_mask[m_s]) ? ~(one << m_s) : 4'hF;
    check("model_S", s, m_s);
    check("model_AN", an, exp_an);
    check("model_tick", tick, m_tick);
    check("model_blank", blank, m_fresh ? 1'b0 : hidden);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic restart_scan(input logic [3:0] m);
    rst = 1'b1; en = 1'b0; ch_en = m;
    cycle();
    rst = 1'b0; en = 1'b1;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] ch;
    logic [1:0] s;
    logic [3:0] an;
    logic       tk;
    logic       bl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic e, input logic [3:0] c,
                             input logic [1:0] es, input logic [3:0] ea,
                             input logic et, input logic eb);
    vec_t x;
    x.rst = r; x.en = e; x.ch = c;
    x.s = es; x.an = ea; x.tk = et; x.bl = eb;
    return x;
  endfunction

  initial begin
    logic [3:0] one;
    logic [3:0] ac;
    logic [1:0] c;
    logic [1:0] e_s2;
    logic [3:0] e_an2;
    one = 4'b0001;

    tbl.push_back(v(1, 0, 4'hF, 0, 4'hF, 0, 0));
`ifdef MUX_SCAN_BLANK_EN
    tbl.push_back(v(0, 1, 4'hF, 0, 4'hF, 0, 1));
    for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 4'hF, 0, 4'hE, 0, 0));
`else
    for (int k = 0; k < 4; k++) tbl.push_back(v(0, 1, 4'hF, 0, 4'hE, 0, 0));
`endif
    for (int g = 1; g <= 4; g++) begin
      c = 2'(g % 4);
      ac = ~(one << c);
`ifdef MUX_SCAN_BLANK_EN
      tbl.push_back(v(0, 1, 4'hF, c, 4'hF, 1, 1));
`else
      tbl.push_back(v(0, 1, 4'hF, c, ac, 1, 0));
`endif
      for (int k = 0; k < 3; k++) tbl.push_back(v(0, 1, 4'hF, c, ac, 0, 0));
    end

    // Full scan of all four channels; dut2 runs the 2-cycle, no-blank corner
    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; ch_en = tbl[i].ch;
      cycle();
      check("tbl_S", s, tbl[i].s);
      check("tbl_AN", an, tbl[i].an);
      check("tbl_tick", tick, tbl[i].tk);
      check("tbl_blank", blank, tbl[i].bl);
      e_s2 = (i == 0) ? 2'd0 : 2'(((i - 1) / 2) % 4);
      e_an2 = (i == 0) ? 4'hF : ~(one << e_s2);
      check("p2_S", s2, e_s2);
      check("p2_AN", an2, e_an2);
      check("p2_tick", tick2, (i >= 3) && (i % 2 == 1));
      check("p2_blank", blank2, 1'b0);
    end

    // Two channels enabled: 0 and 2 alternate
    restart_scan(4'b0101);
    repeat (4) cycle();
    cycle();
    check("alt_S2", s, 2'd2);
    check("alt_tick", tick, 1'b1);
    check("alt_AN_adv", an, (BE > 0) ? 4'hF : 4'b1011);
    cycle();
    check("alt_AN_show", an, 4'b1011);
    repeat (2) cycle();
    cycle();
    check("alt_S0", s, 2'd0);
    check("alt_tick0", tick, 1'b1);

    // Mask cleared mid-scan, then only channel 3 restored
    restart_scan(4'hF);
    repeat (6) cycle();
    check("mask_pre_S", s, 2'd1);
    ch_en = 4'h0;
    cycle();
    check("mask_off_AN", an, 4'hF);
    check("mask_off_blank", blank, 1'b1);
    check("mask_off_S", s, 2'd1);
    cycle();
    check("mask_hold_S", s, 2'd1);
    ch_en = 4'b1000;
    cycle();
    check("mask_on_S", s, 2'd3);
    check("mask_on_tick", tick, 1'b1);
    check("mask_on_AN", an, (BE > 0) ? 4'hF : 4'b0111);
    cycle();
    check("mask_show_AN", an, 4'b0111);

    // Enable dropped at prescaler 2 restarts the period
    restart_scan(4'hF);
    repeat (3) cycle();
    en = 1'b0;
    repeat (3) begin
      cycle();
      check("en_off_tick", tick, 1'b0);
      check("en_off_blank", blank, 1'b1);
    end
    en = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      cycle();
      check("en_on_tick", tick, k == 5);
    end
    check("en_on_S", s, 2'd1);

    // Reset while channel 2 is showing
    restart_scan(4'hF);
    repeat (10) cycle();
    check("rst_pre_S", s, 2'd2);
    rst = 1'b1;
    cycle();
    check("rst_S", s, 2'd0);
    check("rst_AN", an, 4'hF);
    check("rst_tick", tick, 1'b0);
    check("rst_blank", blank, 1'b0);
    rst = 1'b0;
    cycle();

    for (int k = 0; k < 600; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 9) == 0) ch_en = 4'($urandom);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter PRESCALE, default 100000: scan period per channel, in clk cycles; legal range 2 or more.
REQ-002 Parameter BLANK, default 1000: blanking cycles after each channel advance; legal range 0 to PRESCALE-1.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  scan enable.
REQ-006 ch_en  in  4  channel enable mask; bit i enables channel i.
REQ-007 S  out  2  select code to the downstream 4:1 mux.
REQ-008 AN  out  4  active-low one-hot channel strobe.
REQ-009 tick  out  1  one-cycle pulse on each channel advance.
REQ-010 blank  out  1  high while strobes are suppressed.

Function
REQ-011 SHALL implement FSM states IDLE, BLANKING, SHOW; all outputs SHALL be registered.
REQ-012 IDLE: prescaler=0; AN=4'b1111; blank=1; S holds. Exit to SHOW (or BLANKING if BLANK>0) when en=1 and ch_en!=0.
REQ-013 On IDLE exit, if ch_en[S]=0, S SHALL move to the next enabled channel, searching S+1, S+2, S+3 mod 4; tick SHALL pulse only if S changed.
REQ-014 In SHOW/BLANKING, prescaler SHALL count 0..PRESCALE-1 and wrap.
REQ-015 Prescaler wrap (terminal count PRESCALE-1) SHALL trigger the channel advance. In the next cycle:
  - prescaler=0;
  - S=next enabled channel, round-robin search S+1..S+3 mod 4; holds if no other channel is enabled;
  - tick=1;
  - state=BLANKING if BLANK>0, else SHOW.
REQ-016 BLANKING: AN=4'b1111, blank=1; SHALL transition to SHOW when prescaler reaches BLANK.
REQ-017 SHOW: AN=~(4'b0001<<S) when ch_en[S]=1, else 4'b1111; blank=0.
REQ-018 Changes to ch_en SHALL take effect on AN one cycle later; S SHALL change only at an advance or on IDLE exit.
REQ-019 en=0 or ch_en=0 in any state SHALL force IDLE on the next cycle, overriding a simultaneous advance.
REQ-020 PRESCALE=2, BLANK=0: S SHALL advance every 2 cycles, with no blanking cycles.

Reset
REQ-021 rst=1 SHALL, on the next rising edge, regardless of state or en, set:
  - S=2'b00, AN=4'b1111, tick=0, blank=0;
  - prescaler=0, state=IDLE.
REQ-022 Reset mid-period SHALL discard a pending advance.

Configuration
REQ-023 Macro MUX_SCAN_BLANK_EN:
  - Defined: BLANKING state and BLANK parameter are active, as specified above.
  - Undefined: BLANKING is absent, BLANK is ignored, advances go directly to SHOW, and blank=1 only in IDLE.

Verification (PRESCALE=4, BLANK=1, macro defined unless noted)
REQ-024 rst pulse, then en=1, ch_en=4'b1111 -> S=0,1,2,3,0 changing every 4 cycles; tick high 1 cycle at each change; AN=1111 for 1 cycle after each tick, then 1110/1101/1011/0111.
REQ-025 ch_en=4'b0101 -> S alternates 0,2,0,2 every 4 cycles; AN alternates 1110 and 1011 (with blank cycles).
REQ-026 ch_en driven 4'b0000 mid-scan -> next cycle AN=1111, blank=1, S frozen; restoring 4'b1000 with S=1 -> S=3 with a tick, AN=0111 after blanking.
REQ-027 en=0 for 3 cycles at prescaler=2 -> IDLE, prescaler=0, no tick; en=1 -> full 4-cycle period before the next advance.
REQ-028 rst=1 while S=2 in SHOW -> next cycle S=0, AN=1111, tick=0, state IDLE.
REQ-029 Macro undefined, ch_en=4'b1111 -> blank stays 0 after the first advance; AN low on the same cycle as each tick.
